// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the line-memory request arbiter: source select, per-source
// FSM states and the request record seen on the memory side.
package mem_req_arbiter_pkg;

  localparam int PA_WIDTH_DEF   = 32;
  localparam int LINE_BYTES_DEF = 16;
  localparam int ID_WIDTH_DEF   = 2;

  // Posted writes carry this ID; read tags start at 1.
  localparam int WRITE_ID = 0;

  typedef enum logic {SRC_INSTR, SRC_DATA} src_e;

  typedef enum logic {ST_IDLE, ST_WAIT} src_state_e;

  typedef struct packed {
    logic                        write;
    logic [PA_WIDTH_DEF-1:0]     addr;
    logic [LINE_BYTES_DEF*8-1:0] data;
    logic [ID_WIDTH_DEF-1:0]     id;
  } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_tag_alloc.sv
// Free-tag pool for read transactions. Tags freed this cycle are visible to the
// allocator in the same cycle, so an ack and a new read can share a tag.
module mem_req_arbiter_tag_alloc #(
  parameter int ID_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(2**ID_WIDTH)-1:0]   i_free_mask,
  input  logic                       i_alloc,
  output logic [ID_WIDTH-1:0]        o_alloc_id,
  output logic                       o_empty
);

  localparam int NTAGS = 2**ID_WIDTH;
  // Bit 0 is the write ID and never enters the pool.
  localparam logic [NTAGS-1:0] READ_TAGS = {{(NTAGS-1){1'b1}}, 1'b0};

  logic [NTAGS-1:0] free_q;
  logic [NTAGS-1:0] avail;

  assign avail   = (free_q | i_free_mask) & READ_TAGS;
  assign o_empty = ~|avail;

  always_comb begin
    o_alloc_id = '0;
    for (int t = NTAGS - 1; t >= 1; t--) begin
      if (avail[t]) o_alloc_id = t[ID_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_q <= READ_TAGS;
    end else begin
      free_q <= avail;
      if (i_alloc) free_q[o_alloc_id] <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter between fetch and data engines onto the line memory.
// Reads hold a tag until acked; posted writes issue with the write ID.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int PA_WIDTH   = 32,
  parameter int LINE_BYTES = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_instr_enable,
  input  logic [PA_WIDTH-1:0]       i_instr_addr,
  input  logic                      i_instr_ack,
  input  logic                      i_data_enable,
  input  logic [PA_WIDTH-1:0]       i_data_addr,
  input  logic [LINE_BYTES*8-1:0]   i_data,
  input  logic                      i_data_write,
  input  logic                      i_data_ack,
  input  logic                      i_mem_full,
  output logic                      o_mem_enable,
  output logic                      o_mem_write,
  output logic [PA_WIDTH-1:0]       o_mem_addr,
  output logic [LINE_BYTES*8-1:0]   o_mem_data,
  output logic [ID_WIDTH-1:0]       o_mem_id,
  output logic                      o_instr_grant,
  output logic                      o_data_grant,
  output logic [ID_WIDTH-1:0]       o_instr_id,
  output logic [ID_WIDTH-1:0]       o_data_id,
  output src_state_e                dbg_instr_state,
  output src_state_e                dbg_data_state
);

  localparam int NTAGS = 2**ID_WIDTH;

  // Handshake: a source raises enable and holds it; issue is signalled by a
  // one-cycle grant. Reads then wait for the source's ack pulse, writes do not.
  // The memory side has no ready; i_mem_full=1 blocks issue in that cycle.

  src_state_e          instr_st, data_st;
  src_e                last_q;
  logic                instr_free, data_free;
  logic [NTAGS-1:0]    free_mask;
  logic                instr_elig, data_elig;
  logic                issue, pick_data, grant_read;
  logic [ID_WIDTH-1:0] alloc_id;
  logic                tag_empty;

  assign dbg_instr_state = instr_st;
  assign dbg_data_state  = data_st;

  // Acks are honoured even under back-pressure so a pulse is never lost.
  assign instr_free = (instr_st == ST_WAIT) && i_instr_ack;
  assign data_free  = (data_st == ST_WAIT) && i_data_ack;

  always_comb begin
    free_mask = '0;
    if (instr_free) free_mask[o_instr_id] = 1'b1;
    if (data_free)  free_mask[o_data_id]  = 1'b1;
  end

  assign instr_elig = i_instr_enable && (instr_st == ST_IDLE) && !tag_empty;
  assign data_elig  = i_data_enable && (data_st == ST_IDLE) && (i_data_write || !tag_empty);
  assign issue      = (instr_elig || data_elig) && !i_mem_full;
  assign pick_data  = data_elig && (!instr_elig || (last_q == SRC_INSTR));
  assign grant_read = issue && (!pick_data || !i_data_write);

  mem_req_arbiter_tag_alloc #(
    .ID_WIDTH(ID_WIDTH)
  ) u_tag_alloc (
    .clk         (clk),
    .rst         (rst),
    .i_free_mask (free_mask),
    .i_alloc     (grant_read),
    .o_alloc_id  (alloc_id),
    .o_empty     (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_st      <= ST_IDLE;
      data_st       <= ST_IDLE;
      last_q        <= SRC_INSTR;
      o_mem_enable  <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_data    <= '0;
      o_mem_id      <= '0;
      o_instr_grant <= 1'b0;
      o_data_grant  <= 1'b0;
      o_instr_id    <= '0;
      o_data_id     <= '0;
    end else begin
      o_mem_enable  <= issue;
      o_instr_grant <= issue && !pick_data;
      o_data_grant  <= issue && pick_data;
      o_mem_write   <= issue && pick_data && i_data_write;
      o_mem_addr    <= !issue ? '0 : (pick_data ? i_data_addr : i_instr_addr);
      o_mem_data    <= (issue && pick_data && i_data_write) ? i_data : '0;
      o_mem_id      <= grant_read ? alloc_id : ID_WIDTH'(WRITE_ID);

      if (instr_free) begin
        instr_st   <= ST_IDLE;
        o_instr_id <= '0;
      end
      if (data_free) begin
        data_st   <= ST_IDLE;
        o_data_id <= '0;
      end

      // The winner is always IDLE, so it never collides with its own ack above.
      if (issue) begin
        last_q <= pick_data ? SRC_DATA : SRC_INSTR;
        if (!pick_data) begin
          instr_st   <= ST_WAIT;
          o_instr_id <= alloc_id;
        end else if (!i_data_write) begin
          data_st   <= ST_WAIT;
          o_data_id <= alloc_id;
        end
      end
    end
  end

endmodule
